lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store controller for the RV32I core's data path. It accepts byte-addressed load and store requests from the execute stage and drives the word-addressed data memory port. That port has a combinational read, a synchronous write, and no byte enables. Sub-word stores are implemented as read-modify-write. Load data is lane-extracted and sign- or zero-extended according to funct3.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of the CPU byte address
- MEM_ADDR_WIDTH, `_MEM_ADDR_WIDTH_`, width of the data-memory word index
- DATA_WIDTH, `_MEM_DATA_WIDTH_` (32), memory word width; only 32 is supported

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- i_Req  in  1  request strobe; sampled only in IDLE
- i_We  in  1  1 = store, 0 = load
- i_Funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- i_Addr  in  ADDR_WIDTH  byte address
- i_WData  in  DATA_WIDTH  store data (rs2)
- o_Busy  out  1  high in every state except IDLE
- o_Done  out  1  one-cycle completion pulse
- o_Fault  out  1  valid with o_Done; misaligned access or illegal funct3
- o_RData  out  DATA_WIDTH  extended load result; held until the next load completes
- o_MemAddr  out  MEM_ADDR_WIDTH  word index to memory
- o_MemDataOut  out  DATA_WIDTH  write word to memory
- o_MemWrEn  out  1  memory write enable
- i_MemDataIn  in  DATA_WIDTH  combinational read word from memory

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE, i_Req=1: latch i_Addr, i_WData, i_Funct3 and i_We. Then take the first matching branch:
  - Fault → DONE with fault flag set. Fault means any of:
    - halfword access with addr[0]=1
    - word access with addr[1:0]≠0
    - load funct3 ∈ {3,6,7}
    - store funct3 ∉ {0,1,2}
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
- Word index: o_MemAddr = addr[MEM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo memory size.
- LOAD:
  - Capture i_MemDataIn.
  - Select the lane: byte addr[1:0], halfword addr[1].
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
  - Register the result into o_RData, then → DONE.
- RMW_RD:
  - Capture i_MemDataIn into the merge register.
  - Replace the addressed byte with i_WData[7:0] (SB) or the addressed halfword with i_WData[15:0] (SH); keep all other lanes.
  - → WRITE.
- WRITE:
  - o_MemWrEn=1 for exactly this cycle.
  - o_MemDataOut = merged word (SB/SH) or latched i_WData (SW).
  - The memory commits at the rising edge ending this cycle. → DONE.
- DONE: o_Done=1 and o_Fault=fault flag. → IDLE. A faulting access never asserts o_MemWrEn and leaves o_RData unchanged.
- o_MemWrEn is decoded from the registered state only and must be glitch-free. It is 0 in every state except WRITE.
- o_MemAddr holds the latched index from acceptance until the next acceptance.

## Timing
- Reset values: state IDLE; o_Busy, o_Done, o_Fault, o_MemWrEn = 0; o_RData, o_MemAddr, o_MemDataOut = 0.
- Request accepted at edge N (end of the IDLE cycle). o_Done is high in cycle:
  - N+2 for loads and SW
  - N+3 for SB/SH
  - N+1 for faults
- Back-to-back: a new i_Req is accepted at the edge ending the first IDLE cycle after DONE. Minimum issue interval is 3 cycles for loads and SW, 4 for SB/SH.
- i_Req while o_Busy=1, including the DONE cycle, is ignored, not queued. The requester holds i_Req until it observes o_Busy.
- Request inputs are don't-care after acceptance.
- Reset mid-operation: return to IDLE immediately. o_MemWrEn drops asynchronously. No partial write may be issued after reset deasserts.

## Test plan
- Preload word 5 = 0x8899AABB. LB at 0x16 → o_RData=0xFFFFFF99, o_Done at N+2, o_Fault=0. LBU at 0x16 → 0x00000099. LHU at 0x16 → 0x00008899.
- SB i_WData=0x12345678 at 0x15 → o_MemWrEn in N+2 only, word 5 = 0x889978BB. Then SH 0xCAFE at 0x16 → word 5 = 0xCAFE78BB. Then LW 0x14 returns 0xCAFE78BB.
- SW 0xDEADBEEF at 0x20 → word 8 = 0xDEADBEEF, done at N+2. Address 4·2^MEM_ADDR_WIDTH+0x20 writes the same word (wrap).
- LW at 0x13, SH at 0x15, load funct3=3 → o_Done and o_Fault at N+1, o_MemWrEn never high, o_RData unchanged.
- Assert reset during the RMW_RD cycle of an SB → o_MemWrEn never rises, o_Busy=0 in the cycle after reset deasserts, target word unchanged.
- Hold i_Req high continuously with alternating LW/SB → each accepted only from IDLE, exactly one o_Done pulse per transaction.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store controller for a word-addressed memory; sub-word stores use read-modify-write
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_Req,
    input  logic                      i_We,
    input  logic [2:0]                i_Funct3,
    input  logic [ADDR_WIDTH-1:0]     i_Addr,
    input  logic [DATA_WIDTH-1:0]     i_WData,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic                      o_Fault,
    output logic [DATA_WIDTH-1:0]     o_RData,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]     o_MemDataOut,
    output logic                      o_MemWrEn,
    input  logic [DATA_WIDTH-1:0]     i_MemDataIn
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [MEM_ADDR_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, merge_q, load_n, merge_n, ins_mask;
    logic [2:0] funct3_q;
    logic fault_q, fault_n, unused_addr;
    logic [4:0] sh;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    // Bits above the memory index are dropped so addresses wrap modulo memory size
    assign unused_addr = ^i_Addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];
    always_comb begin
        fault_n = (i_We ? i_Funct3 > 3'd2 : (i_Funct3 == 3'd3 || i_Funct3[2:1] == 2'b11))
                  || (i_Funct3[1:0] == 2'd1 && i_Addr[0])
                  || (i_Funct3[1:0] == 2'd2 && i_Addr[1:0] != 2'd0);
        state_n = IDLE;
        case (state)
            IDLE:    state_n = !i_Req ? IDLE : fault_n ? DONE : !i_We ? LOAD
                               : i_Funct3[1:0] == 2'd2 ? WRITE : RMW_RD;
            LOAD:    state_n = DONE;
            RMW_RD:  state_n = WRITE;
            WRITE:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        sh = {addr_q[1:0], 3'b000};
        lane_b = 8'(i_MemDataIn >> sh);
        lane_h = addr_q[1] ? i_MemDataIn[31:16] : i_MemDataIn[15:0];
        load_n = funct3_q[1:0] == 2'd0 ? {{24{~funct3_q[2] & lane_b[7]}}, lane_b}
               : funct3_q[1:0] == 2'd1 ? {{16{~funct3_q[2] & lane_h[15]}}, lane_h}
               : i_MemDataIn;
        ins_mask = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        merge_n = (i_MemDataIn & ~ins_mask) | ((wdata_q << sh) & ins_mask);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            fault_q  <= 1'b0;
            merge_q  <= '0;
            o_RData  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && i_Req) begin
                addr_q   <= i_Addr[MEM_ADDR_WIDTH+1:0];
                wdata_q  <= i_WData;
                funct3_q <= i_Funct3;
                fault_q  <= fault_n;
            end
            if (state == LOAD) o_RData <= load_n;
            if (state == RMW_RD) merge_q <= merge_n;
        end
    end
    assign o_Busy       = state != IDLE;
    assign o_Done       = state == DONE;
    assign o_Fault      = o_Done & fault_q;
    assign o_MemWrEn    = state == WRITE;
    assign o_MemAddr    = addr_q[MEM_ADDR_WIDTH+1:2];
    assign o_MemDataOut = o_MemWrEn ? (funct3_q[1:0] == 2'd2 ? wdata_q : merge_q) : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench for lsu_mem_ctrl with a behavioural word memory
module tb_lsu_mem_ctrl;
    localparam int MAW = 10;
    logic clk = 0, reset = 1;
    logic i_Req = 0, i_We = 0;
    logic [2:0] i_Funct3 = 0;
    logic [31:0] i_Addr = 0, i_WData = 0;
    logic o_Busy, o_Done, o_Fault, o_MemWrEn;
    logic [31:0] o_RData, o_MemDataOut, i_MemDataIn;
    logic [MAW-1:0] o_MemAddr;
    logic [31:0] mem [0:(1<<MAW)-1];
    int asserts = 0, failures = 0, wr_seen = 0;

    lsu_mem_ctrl #(.ADDR_WIDTH(32), .MEM_ADDR_WIDTH(MAW), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .i_Req(i_Req), .i_We(i_We), .i_Funct3(i_Funct3),
        .i_Addr(i_Addr), .i_WData(i_WData), .o_Busy(o_Busy), .o_Done(o_Done),
        .o_Fault(o_Fault), .o_RData(o_RData), .o_MemAddr(o_MemAddr),
        .o_MemDataOut(o_MemDataOut), .o_MemWrEn(o_MemWrEn), .i_MemDataIn(i_MemDataIn)
    );

    always #5 clk = ~clk;
    assign i_MemDataIn = mem[o_MemAddr];
    always @(posedge clk) begin
        if (o_MemWrEn) begin
            mem[o_MemAddr] <= o_MemDataOut;
            wr_seen <= wr_seen + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issues one request from IDLE; lat is the cycle (after the accept edge) carrying o_Done
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic flt, output int wrs, output int wr_at);
        @(posedge clk); #1;
        i_Req = 1; i_We = we; i_Funct3 = f3; i_Addr = addr; i_WData = wd;
        @(posedge clk); #1;
        i_Req = 0; i_We = ~we; i_Funct3 = 3'd7; i_Addr = '1; i_WData = '1;
        lat = -1; flt = 1'bx; wrs = 0; wr_at = -1;
        for (int c = 1; c <= 8; c++) begin
            if (o_MemWrEn) begin wrs++; wr_at = c; end
            if (o_Done) begin lat = c; flt = o_Fault; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        #2;
        chk("rst_busy", 32'(o_Busy), 0);
        chk("rst_done", 32'(o_Done), 0);
        chk("rst_fault", 32'(o_Fault), 0);
        chk("rst_wren", 32'(o_MemWrEn), 0);
        chk("rst_rdata", o_RData, 0);
        chk("rst_memaddr", 32'(o_MemAddr), 0);
        chk("rst_memdata", o_MemDataOut, 0);
        @(posedge clk); #1 reset = 0;
    endtask

    task automatic test_loads;
        int lat, wrs, wa;
        logic flt;
        mem[5] = 32'h8899AABB;
        run(0, 3'd0, 32'h16, 0, lat, flt, wrs, wa);
        chk("lb_data", o_RData, 32'hFFFFFF99);
        chk("lb_lat", 32'(lat), 2);
        chk("lb_fault", 32'(flt), 0);
        chk("lb_nowr", 32'(wrs), 0);
        run(0, 3'd4, 32'h16, 0, lat, flt, wrs, wa);
        chk("lbu_data", o_RData, 32'h00000099);
        run(0, 3'd5, 32'h16, 0, lat, flt, wrs, wa);
        chk("lhu_data", o_RData, 32'h00008899);
        run(0, 3'd1, 32'h14, 0, lat, flt, wrs, wa);
        chk("lh_data", o_RData, 32'hFFFFAABB);
        run(0, 3'd0, 32'h14, 0, lat, flt, wrs, wa);
        chk("lb0_data", o_RData, 32'hFFFFFFBB);
    endtask

    task automatic test_stores;
        int lat, wrs, wa;
        logic flt;
        run(1, 3'd0, 32'h15, 32'h12345678, lat, flt, wrs, wa);
        chk("sb_lat", 32'(lat), 3);
        chk("sb_wrcnt", 32'(wrs), 1);
        chk("sb_wrcycle", 32'(wa), 2);
        chk("sb_fault", 32'(flt), 0);
        chk("sb_mem", mem[5], 32'h889978BB);
        run(1, 3'd1, 32'h16, 32'h0000CAFE, lat, flt, wrs, wa);
        chk("sh_lat", 32'(lat), 3);
        chk("sh_mem", mem[5], 32'hCAFE78BB);
        run(0, 3'd2, 32'h14, 0, lat, flt, wrs, wa);
        chk("lw_data", o_RData, 32'hCAFE78BB);
        chk("lw_lat", 32'(lat), 2);
        run(1, 3'd2, 32'h20, 32'hDEADBEEF, lat, flt, wrs, wa);
        chk("sw_lat", 32'(lat), 2);
        chk("sw_wrcycle", 32'(wa), 1);
        chk("sw_mem", mem[8], 32'hDEADBEEF);
        mem[8] = 0;
        run(1, 3'd2, (32'd4 << MAW) + 32'h20, 32'hDEADBEEF, lat, flt, wrs, wa);
        chk("sw_wrap_mem", mem[8], 32'hDEADBEEF);
        run(1, 3'd2, (32'd4 << MAW) + 32'h20, 32'h11223344, lat, flt, wrs, wa);
        chk("sw_wrap2_mem", mem[8], 32'h11223344);
        chk("rdata_held", o_RData, 32'hCAFE78BB);
    endtask

    task automatic test_faults;
        int lat, wrs, wa;
        logic flt;
        logic [31:0] prev;
        logic [31:0] vec_addr [4] = '{32'h13, 32'h15, 32'h10, 32'h14};
        logic [2:0] vec_f3 [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic vec_we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        prev = o_RData;
        for (int i = 0; i < 4; i++) begin
            run(vec_we[i], vec_f3[i], vec_addr[i], 32'hA5A5A5A5, lat, flt, wrs, wa);
            chk($sformatf("fault%0d_lat", i), 32'(lat), 1);
            chk($sformatf("fault%0d_flag", i), 32'(flt), 1);
            chk($sformatf("fault%0d_nowr", i), 32'(wrs), 0);
            chk($sformatf("fault%0d_rdata", i), o_RData, prev);
        end
        chk("fault_mem5", mem[5], 32'hCAFE78BB);
    endtask

    task automatic test_reset_mid;
        int w0;
        mem[6] = 32'h01020304;
        @(posedge clk); #1;
        i_Req = 1; i_We = 1; i_Funct3 = 3'd0; i_Addr = 32'h18; i_WData = 32'h55;
        @(posedge clk); #1;
        i_Req = 0;
        w0 = wr_seen;
        chk("mid_busy_before", 32'(o_Busy), 1);
        reset = 1; #1;
        chk("mid_wren_async", 32'(o_MemWrEn), 0);
        chk("mid_busy_async", 32'(o_Busy), 0);
        @(posedge clk); #1 reset = 0;
        chk("mid_busy_after", 32'(o_Busy), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_later", 32'(o_Busy), 0);
        chk("mid_nowr", 32'(wr_seen - w0), 0);
        chk("mid_mem", mem[6], 32'h01020304);
    endtask

    task automatic test_back_to_back;
        int acc = 0, dones = 0, wrs = 0, dbl = 0;
        logic pb = 0, pd = 0, sb_next = 1;
        @(posedge clk); #1;
        i_Req = 1; i_We = 0; i_Funct3 = 3'd2; i_Addr = 32'h20; i_WData = 32'hA5;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (!pb && o_Busy) begin
                acc++;
                i_We = sb_next; i_Funct3 = sb_next ? 3'd0 : 3'd2; i_Addr = sb_next ? 32'h21 : 32'h20;
                sb_next = ~sb_next;
            end
            if (o_Done) dones++;
            if (o_Done && pd) dbl++;
            if (o_MemWrEn) wrs++;
            pb = o_Busy; pd = o_Done;
        end
        i_Req = 0;
        chk("b2b_accepts", 32'(acc), 4);
        chk("b2b_dones", 32'(dones), 4);
        chk("b2b_double_done", 32'(dbl), 0);
        chk("b2b_writes", 32'(wrs), 2);
        chk("b2b_mem", mem[8], 32'h1122A544);
        chk("b2b_rdata", o_RData, 32'h1122A544);
    endtask

    initial begin
        for (int i = 0; i < (1 << MAW); i++) mem[i] = 0;
        test_reset;
        test_loads;
        test_stores;
        test_faults;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
